peripheral_spram_wb_initiator: RTL and testbench

- Wishbone B3 bus master: the initiator end of the interface served by the SPRAM Wishbone slave.
- Converts single-command requests (address, beat count, direction) into classic single cycles or linear incrementing bursts (cti/bte).
- Streams write data in and read data out through valid/ready side ports.
- Used as the traffic generator and DMA-style front end driving the SPRAM during synthesis and bring-up.

---
 rtl/peripheral_spram_wb_initiator.sv | 151 +++++++++++++++
 tb/tb_peripheral_spram_wb_initiator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_spram_wb_initiator.sv
// Wishbone B3 master: turns one (address, length, direction) command into classic or
// linear incrementing burst cycles, streaming write data in and read data out.
module peripheral_spram_wb_initiator #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int LW = 5
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  output logic            rdat_valid_o,
  output logic [DW-1:0]   rdat_o,
  output logic            rdat_last_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic [1:0]      wb_bte_o,
  output logic [2:0]      wb_cti_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic [DW-1:0]   wb_dat_i
);

  typedef enum logic [1:0] {IDLE, FETCH, BEAT} state_t;

  state_t        state;
  logic [LW-1:0] remaining;
  logic          single;
  logic [LW-1:0] cmd_len_eff;
  logic          cmd_single;
  logic          last_beat;

  assign cmd_len_eff = (cmd_len_i == '0) ? LW'(1) : cmd_len_i;
  assign cmd_single  = (cmd_len_i <= LW'(1));
  assign last_beat   = (remaining == LW'(1));
  assign wb_bte_o    = 2'b00;

  // Cycle type for the beat about to be presented, given the beats still owed.
  function automatic logic [2:0] cti_for(input logic [LW-1:0] rem, input logic one);
    if (one) return 3'b000;
    if (rem > LW'(1)) return 3'b010;
    return 3'b111;
  endfunction

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      remaining    <= '0;
      single       <= 1'b0;
      cmd_ready_o  <= 1'b1;
      wdat_ready_o <= 1'b0;
      rdat_valid_o <= 1'b0;
      rdat_o       <= '0;
      rdat_last_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_cti_o     <= 3'b000;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
    end else begin
      rdat_valid_o <= 1'b0;
      rdat_last_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        IDLE: begin
          // Ready rises one cycle after done_o, so back-to-back commands never overlap.
          if (cmd_ready_o && cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            wb_adr_o    <= cmd_adr_i;
            wb_we_o     <= cmd_we_i;
            wb_sel_o    <= cmd_sel_i;
            remaining   <= cmd_len_eff;
            single      <= cmd_single;
            wb_cyc_o    <= 1'b1;
            if (cmd_we_i) begin
              wdat_ready_o <= 1'b1;
              state        <= FETCH;
            end else begin
              wb_stb_o <= 1'b1;
              wb_cti_o <= cti_for(cmd_len_eff, cmd_single);
              state    <= BEAT;
            end
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end
        FETCH: begin
          if (wdat_valid_i) begin
            wb_dat_o     <= wdat_i;
            wdat_ready_o <= 1'b0;
            wb_stb_o     <= 1'b1;
            wb_cti_o     <= cti_for(remaining, single);
            state        <= BEAT;
          end
        end
        BEAT: begin
          if (wb_ack_i && !wb_err_i) begin
            remaining <= remaining - LW'(1);
            wb_adr_o  <= wb_adr_o + AW'(1);
            if (!wb_we_o) begin
              rdat_o       <= wb_dat_i;
              rdat_valid_o <= 1'b1;
              rdat_last_o  <= last_beat;
            end
            if (!last_beat) begin
              if (wb_we_o) begin
                wb_stb_o     <= 1'b0;
                wdat_ready_o <= 1'b1;
                state        <= FETCH;
              end else begin
                wb_cti_o <= cti_for(remaining - LW'(1), single);
              end
            end
          end
          // Error takes priority over a simultaneous ack and discards the rest.
          if (wb_err_i || (wb_ack_i && last_beat)) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_cti_o  <= 3'b000;
            remaining <= '0;
            done_o    <= 1'b1;
            err_o     <= wb_err_i;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_spram_wb_initiator.sv
// Randomized bench: behavioural SPRAM slave, write-data source and a command-level
// reference model that predicts every bus beat, read word and completion.
module tb_peripheral_spram_wb_initiator;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic [3:0]    cmd_sel_i = '0;
  logic          wdat_valid_i = 1'b0;
  logic          wdat_ready_o;
  logic [DW-1:0] wdat_i = '0;
  logic          rdat_valid_o;
  logic [DW-1:0] rdat_o;
  logic          rdat_last_o;
  logic          done_o;
  logic          err_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic [1:0]    wb_bte_o;
  logic [2:0]    wb_cti_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;
  logic [DW-1:0] wb_dat_i = '0;

  peripheral_spram_wb_initiator #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .rdat_last_o(rdat_last_o),
    .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] wdata   [32];
  logic [31:0] rexp    [$];

  int          exp_n, wcount, err_beat, gap_before, gap_left;
  bit          gap_done, busy;
  logic [7:0]  exp_adr;
  logic        exp_we;
  logic [3:0]  exp_sel;
  int          beat_idx, ack_cnt, rd_cnt, done_cnt, err_cnt, wptr, stb_low, cyc_drop;
  int          ack_pct = 100;
  int          wv_pct = 100;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Environment and monitors run on the falling edge; values driven here are
  // what the DUT samples on the next rising edge.
  always @(negedge clk) begin
    logic v;
    v = 1'b0;
    if (wptr == gap_before && !gap_done) begin
      gap_left = 5;
      gap_done = 1'b1;
    end
    if (wptr < wcount) begin
      wdat_i = wdata[wptr];
      if (gap_left > 0) gap_left--;
      else v = ($urandom_range(99) < wv_pct);
    end
    wdat_valid_i = v;
    if (v && wdat_ready_o) wptr++;

    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      wb_dat_i = mem[wb_adr_o];
      if (beat_idx == err_beat) begin
        wb_err_i = 1'b1;
        wb_ack_i = 1'($urandom_range(1));
      end else if ($urandom_range(99) < ack_pct) begin
        wb_ack_i = 1'b1;
      end
      if (wb_ack_i || wb_err_i) begin
        chk("beat_adr", wb_adr_o, 64'((exp_adr + beat_idx) & 8'hFF));
        chk("beat_cti", wb_cti_o, (exp_n == 1) ? 0 : ((beat_idx == exp_n - 1) ? 7 : 2));
        chk("beat_we", wb_we_o, exp_we);
        chk("beat_sel", wb_sel_o, exp_sel);
        chk("beat_bte", wb_bte_o, 0);
        if (exp_we) chk("beat_dat", wb_dat_o, wdata[beat_idx]);
        if (!wb_err_i) begin
          ack_cnt++;
          if (wb_we_o) mem[wb_adr_o] = merge(mem[wb_adr_o], wb_dat_o, wb_sel_o);
        end
        beat_idx++;
      end
    end else if (wb_cyc_o) begin
      stb_low++;
    end

    if (busy && !wb_cyc_o && !done_o) cyc_drop++;
    if (done_o) busy = 1'b0;
    if (cmd_valid_i && cmd_ready_o) busy = 1'b1;

    if (rdat_valid_o) begin
      chk("rdat", rdat_o, (rd_cnt < rexp.size()) ? rexp[rd_cnt] : 32'hx);
      chk("rdat_last", rdat_last_o, (rd_cnt == exp_n - 1));
      rd_cnt++;
    end
    if (err_o && !done_o) chk("err_without_done", 1, 0);
    if (done_o) begin
      done_cnt++;
      if (err_o) err_cnt++;
      if (!exp_we && !err_o) chk("done_with_last", rdat_valid_o && rdat_last_o, 1);
    end
  end

  task automatic setup_cmd(input bit we, input logic [7:0] adr, input int len,
                           input logic [3:0] sel, input int errb, input int gapb);
    int completed;
    exp_n = (len == 0) ? 1 : len;
    exp_adr = adr; exp_we = we; exp_sel = sel;
    err_beat = errb; gap_before = gapb; gap_done = 1'b0; gap_left = 0;
    for (int i = 0; i < 32; i++) wdata[i] = $urandom;
    completed = (errb >= 0 && errb < exp_n) ? errb : exp_n;
    rexp.delete();
    for (int i = 0; i < exp_n; i++) begin
      if (!we) rexp.push_back(ref_mem[(adr + i) & 8'hFF]);
      else if (i < completed) ref_mem[(adr + i) & 8'hFF] = merge(ref_mem[(adr + i) & 8'hFF], wdata[i], sel);
    end
    beat_idx = 0; ack_cnt = 0; rd_cnt = 0; done_cnt = 0; err_cnt = 0;
    wptr = 0; stb_low = 0; cyc_drop = 0;
    wcount = we ? exp_n : 0;
  endtask

  task automatic issue(input bit we, input logic [7:0] adr, input int len, input logic [3:0] sel);
    int t;
    cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = LW'(len); cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    t = 0;
    while (!cmd_ready_o && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!cmd_ready_o) chk("cmd_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_cmd(input bit we, input logic [7:0] adr, input int len,
                         input logic [3:0] sel, input int errb, input int gapb);
    int t;
    bit errored;
    setup_cmd(we, adr, len, sel, errb, gapb);
    issue(we, adr, len, sel);
    t = 0;
    while (!done_o && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    if (!done_o) chk("done_timeout", 0, 1);
    @(negedge clk); #1;
    @(posedge clk); #1;
    chk("ready_after_done", cmd_ready_o, 1);
    errored = (errb >= 0 && errb < exp_n);
    chk("done_count", done_cnt, 1);
    chk("err_count", err_cnt, errored);
    chk("ack_count", ack_cnt, errored ? errb : exp_n);
    chk("rd_count", rd_cnt, we ? 0 : (errored ? errb : exp_n));
    chk("wdat_consumed", wptr, we ? (errored ? errb + 1 : exp_n) : 0);
    chk("cyc_held", cyc_drop, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    exp_n = 1; wcount = 0; err_beat = -1; gap_before = -1; busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdat_valid", rdat_valid_o, 0);
    chk("rst_wdat_ready", wdat_ready_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_cti", wb_cti_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(0, 8'h10, 1, 4'hF, -1, -1);
    chk("deadbeef", rdat_o, 32'hDEADBEEF);
    run_cmd(1, 8'h20, 4, 4'hF, -1, -1);
    run_cmd(0, 8'h20, 4, 4'hF, -1, -1);
    run_cmd(1, 8'h30, 3, 4'hF, -1, 1);
    chk("gap_wait", stb_low >= 5, 1);
    run_cmd(0, 8'hFE, 4, 4'hF, -1, -1);
    run_cmd(0, 8'h50, 8, 4'hF, 2, -1);
    run_cmd(0, 8'h60, 0, 4'hF, -1, -1);
    run_cmd(1, 8'h70, 5, 4'h5, 3, -1);

    for (int k = 0; k < 40; k++) begin
      ack_pct = $urandom_range(100, 30);
      wv_pct = $urandom_range(100, 30);
      run_cmd(1'($urandom_range(1)), 8'($urandom), $urandom_range(31), 4'($urandom),
              ($urandom_range(4) == 0) ? $urandom_range(31) : -1, -1);
    end

    ack_pct = 100; wv_pct = 100;
    setup_cmd(1, 8'hC0, 6, 4'hF, -1, -1);
    issue(1, 8'hC0, 6, 4'hF);
    t = 0;
    while (!(ack_cnt == 2 && wb_stb_o) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("reach_beat2", ack_cnt == 2 && wb_stb_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_cyc", wb_cyc_o, 0);
    chk("arst_stb", wb_stb_o, 0);
    chk("arst_done", done_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    busy = 1'b0;
    @(posedge clk); #1;
    chk("arst_ready", cmd_ready_o, 1);
    chk("arst_done_after", done_cnt, 0);
    run_cmd(0, 8'h10, 1, 4'hF, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
